thermo_zone_ctrl: RTL and testbench

THERMO_ZONE_CTRL -- requirements
Module: thermo_zone_ctrl

---
 rtl/thermo_pkg.sv | 22 ++
 rtl/thermo_zone.sv | 105 ++++++++++
 rtl/thermo_zone_ctrl.sv | 41 ++++
 tb/tb_thermo_zone_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared zone-state encoding and sensor-pair decode constants for the
// thermo zone controller.
package thermo_pkg;

  typedef enum logic [1:0] {
    ZS_IDLE  = 2'd0,
    ZS_HEAT  = 2'd1,
    ZS_COOL  = 2'd2,
    ZS_FAULT = 2'd3
  } zone_state_t;

  // {s_high, s_low}
  localparam logic [1:0] PAIR_COLD    = 2'b00;
  localparam logic [1:0] PAIR_OK      = 2'b01;
  localparam logic [1:0] PAIR_HOT     = 2'b11;
  localparam logic [1:0] PAIR_INVALID = 2'b10;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thermo_zone.sv
// One climate zone: sensor-pair debouncer, minimum-run counter and the
// heat/cool/fault state machine.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ZS_IDLE  | no drive; waits for en with a COLD or HOT filtered pair
//   ZS_HEAT  | heater on; held at least MIN_RUN cycles unless en drops
//   ZS_COOL  | cooler on; held at least MIN_RUN cycles unless en drops
//   ZS_FAULT | latched alarm; leaves on ack once the pair is valid
module thermo_zone
  import thermo_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int MIN_RUN  = 8
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       en,
  input  logic       alarm_ack,
  input  logic [1:0] raw_pair,
  output logic       heat,
  output logic       cool,
  output logic       alarm
);

  localparam int DB_W  = cnt_width(DEBOUNCE);
  localparam int RUN_W = cnt_width(MIN_RUN);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_RUN - 1);

  logic [1:0]       last_pair;
  logic [1:0]       filt_pair;
  logic [DB_W-1:0]  stab_cnt;
  logic [DB_W-1:0]  stab_nxt;
  logic [RUN_W-1:0] run_cnt;
  zone_state_t      state;
  zone_state_t      state_nxt;

  // stab_cnt counts repeats after the first sample; DB_LAST marks the
  // DEBOUNCE-th identical sample, which is when the filtered pair loads.
  always_comb begin
    stab_nxt = '0;
    if (raw_pair == last_pair)
      stab_nxt = (stab_cnt == DB_LAST) ? stab_cnt : stab_cnt + DB_W'(1);
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      last_pair <= PAIR_OK;
      filt_pair <= PAIR_OK;
      stab_cnt  <= '0;
    end else begin
      last_pair <= raw_pair;
      stab_cnt  <= stab_nxt;
      if (stab_nxt == DB_LAST)
        filt_pair <= raw_pair;
    end
  end

  always_comb begin
    state_nxt = state;
    if (filt_pair == PAIR_INVALID) begin
      state_nxt = ZS_FAULT;
    end else begin
      case (state)
        ZS_IDLE: begin
          if (en && filt_pair == PAIR_COLD)     state_nxt = ZS_HEAT;
          else if (en && filt_pair == PAIR_HOT) state_nxt = ZS_COOL;
        end
        ZS_HEAT: begin
          if (!en || (filt_pair != PAIR_COLD && run_cnt == RUN_LAST))
            state_nxt = ZS_IDLE;
        end
        ZS_COOL: begin
          if (!en || (filt_pair != PAIR_HOT && run_cnt == RUN_LAST))
            state_nxt = ZS_IDLE;
        end
        ZS_FAULT: begin
          if (alarm_ack) state_nxt = ZS_IDLE;
        end
        default: state_nxt = ZS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ZS_IDLE;
      run_cnt <= '0;
      heat    <= 1'b0;
      cool    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        run_cnt <= '0;
      else if (run_cnt != RUN_LAST)
        run_cnt <= run_cnt + RUN_W'(1);
      heat  <= (state_nxt == ZS_HEAT);
      cool  <= (state_nxt == ZS_COOL);
      alarm <= (state_nxt == ZS_FAULT);
    end
  end

endmodule

// File: rtl/thermo_zone_ctrl.sv
// Multi-zone thermostat controller: NZONES independent zones plus a
// registered summary alarm.
module thermo_zone_ctrl #(
  parameter int NZONES   = 2,
  parameter int DEBOUNCE = 3,
  parameter int MIN_RUN  = 8
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              en,
  input  logic              alarm_ack,
  input  logic [NZONES-1:0] s_low,
  input  logic [NZONES-1:0] s_high,
  output logic [NZONES-1:0] heat,
  output logic [NZONES-1:0] cool,
  output logic [NZONES-1:0] alarm,
  output logic              alarm_any
);

  for (genvar z = 0; z < NZONES; z++) begin : g_zone
    thermo_zone #(
      .DEBOUNCE (DEBOUNCE),
      .MIN_RUN  (MIN_RUN)
    ) u_zone (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .en        (en),
      .alarm_ack (alarm_ack),
      .raw_pair  ({s_high[z], s_low[z]}),
      .heat      (heat[z]),
      .cool      (cool[z]),
      .alarm     (alarm[z])
    );
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) alarm_any <= 1'b0;
    else          alarm_any <= |alarm;
  end

endmodule

// File: tb/tb_thermo_zone_ctrl.sv
// Bench for thermo_zone_ctrl: directed scenarios then random traffic, all
// compared against a run-length / time-in-state reference model.
module tb_thermo_zone_ctrl;

  localparam int NZ = 2;
  localparam int DB = 3;
  localparam int MR = 8;
  localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_FAULT = 3;

  logic          clk_2 = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          alarm_ack = 1'b0;
  logic [NZ-1:0] s_low, s_high;
  logic [NZ-1:0] heat, cool, alarm;
  logic          alarm_any;

  int n_checks = 0;
  int n_errors = 0;
  int hc;

  int         m_st [NZ];
  int         m_age[NZ];
  int         m_len[NZ];
  logic [1:0] m_prev[NZ];
  logic [1:0] m_filt[NZ];
  logic       m_any;

  thermo_zone_ctrl #(.NZONES(NZ), .DEBOUNCE(DB), .MIN_RUN(MR)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .en        (en),
    .alarm_ack (alarm_ack),
    .s_low     (s_low),
    .s_high    (s_high),
    .heat      (heat),
    .cool      (cool),
    .alarm     (alarm),
    .alarm_any (alarm_any)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NZ-1:0] exp_vec(input int code);
    logic [NZ-1:0] r;
    for (int z = 0; z < NZ; z++) r[z] = (m_st[z] == code);
    return r;
  endfunction

  task automatic set_pair(input int z, input logic [1:0] p);
    s_high[z] = p[1];
    s_low[z]  = p[0];
  endtask

  // Reference: run length of identical samples, cycles spent in a state.
  always @(posedge clk_2 or negedge reset_n) begin
    int nst;
    logic [1:0] f, raw;
    bit demand;
    if (!reset_n) begin
      for (int z = 0; z < NZ; z++) begin
        m_st[z] = M_IDLE; m_age[z] = 0; m_len[z] = 1;
        m_prev[z] = 2'b01; m_filt[z] = 2'b01;
      end
      m_any = 1'b0;
    end else begin
      m_any = |exp_vec(M_FAULT);
      for (int z = 0; z < NZ; z++) begin
        f = m_filt[z];
        nst = m_st[z];
        if (f == 2'b10) nst = M_FAULT;
        else if (m_st[z] == M_IDLE) begin
          if (en && f == 2'b00) nst = M_HEAT;
          else if (en && f == 2'b11) nst = M_COOL;
        end else if (m_st[z] == M_HEAT || m_st[z] == M_COOL) begin
          demand = (m_st[z] == M_HEAT) ? (f == 2'b00) : (f == 2'b11);
          if (!en || (!demand && m_age[z] >= MR - 1)) nst = M_IDLE;
        end else if (alarm_ack) nst = M_IDLE;
        m_age[z] = (nst == m_st[z]) ? m_age[z] + 1 : 0;
        m_st[z] = nst;
        raw = {s_high[z], s_low[z]};
        m_len[z] = (raw == m_prev[z]) ? m_len[z] + 1 : 1;
        m_prev[z] = raw;
        if (m_len[z] >= DB) m_filt[z] = raw;
      end
    end
  end

  task automatic compare_all();
    check_val("heat", heat, exp_vec(M_HEAT));
    check_val("cool", cool, exp_vec(M_COOL));
    check_val("alarm", alarm, exp_vec(M_FAULT));
    check_val("alarm_any", alarm_any, m_any);
    check_val("heat_cool_excl", heat & cool, 0);
  endtask

  task automatic cycle();
    @(posedge clk_2);
    @(negedge clk_2);
    compare_all();
  endtask

  initial begin
    logic [1:0] p;
    int r;
    s_low = '1;
    s_high = '0;
    repeat (2) @(negedge clk_2);
    compare_all();
    check_val("rst_outputs", {heat, cool, alarm, alarm_any}, 0);

    // zone0 COLD from edge 1: filtered at edge 3, heat after edge 4
    en = 1'b1;
    reset_n = 1'b1;
    set_pair(0, 2'b00);
    cycle(); cycle(); cycle();
    check_val("cold_e3_heat0", heat[0], 0);
    cycle();
    check_val("cold_e4_heat0", heat[0], 1);
    check_val("cold_e4_zone1", {heat[1], cool[1], alarm[1]}, 0);

    // HOT while heating: heat held for MIN_RUN, one IDLE, then cool
    cycle();
    set_pair(0, 2'b11);
    hc = 2;
    for (int i = 0; i < 30 && heat[0]; i++) begin
      cycle();
      if (heat[0]) hc++;
    end
    check_val("minrun_heat_len", hc, MR);
    check_val("minrun_gap_cool", cool[0], 0);
    cycle();
    check_val("minrun_cool", cool[0], 1);

    // chattering zone1 never debounces to COLD
    for (int i = 0; i < 16; i++) begin
      set_pair(1, ((i / 2) % 2 != 0) ? 2'b01 : 2'b00);
      cycle();
      check_val("chatter_zone1", {heat[1], cool[1]}, 0);
    end

    // fault while cooling, ignored ack, then valid ack
    set_pair(1, 2'b11);
    for (int i = 0; i < 20 && !cool[1]; i++) cycle();
    check_val("fault_cool1", cool[1], 1);
    set_pair(1, 2'b10);
    repeat (3) cycle();
    check_val("fault_pre", alarm[1], 0);
    cycle();
    check_val("fault_alarm1", alarm[1], 1);
    check_val("fault_cool_off", cool[1], 0);
    check_val("fault_any_lag", alarm_any, 0);
    cycle();
    check_val("fault_any", alarm_any, 1);
    alarm_ack = 1'b1;
    cycle();
    alarm_ack = 1'b0;
    check_val("fault_ack_ignored", alarm[1], 1);
    set_pair(1, 2'b01);
    repeat (3) cycle();
    check_val("fault_hold_no_ack", alarm[1], 1);
    alarm_ack = 1'b1;
    cycle();
    alarm_ack = 1'b0;
    check_val("fault_cleared", alarm[1], 0);
    check_val("fault_any_still", alarm_any, 1);
    cycle();
    check_val("fault_any_clear", alarm_any, 0);

    // en drop early in a heat run
    set_pair(0, 2'b00);
    for (int i = 0; i < 20 && !heat[0]; i++) cycle();
    check_val("endrop_heat_on", heat[0], 1);
    cycle();
    en = 1'b0;
    cycle();
    check_val("endrop_heat_off", heat[0], 0);
    en = 1'b1;

    // async reset in the middle of a fault
    set_pair(0, 2'b10);
    for (int i = 0; i < 20 && !alarm[0]; i++) cycle();
    check_val("arst_alarm_on", alarm[0], 1);
    cycle();
    @(posedge clk_2);
    #2 reset_n = 1'b0;
    #1 check_val("arst_outputs", {heat, cool, alarm, alarm_any}, 0);
    @(negedge clk_2);
    compare_all();
    set_pair(0, 2'b01);
    set_pair(1, 2'b01);
    reset_n = 1'b1;

    // random traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int z = 0; z < NZ; z++) begin
        if ($urandom_range(5) == 0) begin
          r = $urandom_range(15);
          p = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b11 : 2'b10;
          set_pair(z, p);
        end
      end
      if ($urandom_range(24) == 0) en = ~en;
      alarm_ack = ($urandom_range(7) == 0);
      reset_n = ($urandom_range(299) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
